frame_painter: RTL and testbench

Sequencer that owns the background colour lookup and the VGA plot port. It sweeps coordinates into the background lookup for full-frame repaints, and serves rectangular sprite draw/erase jobs from the robot logic. It compensates for the lookup's one-cycle registered latency and emits one plot strobe per visible pixel. It sits between the game control logic and the VGA adapter.

---
 rtl/frame_painter.sv | 171 +++++++++++++++++
 tb/tb_frame_painter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_painter.sv
// Repaint/sprite sequencer driving a registered background lookup and the VGA plot port.
// The scan coordinate leaves combinationally; the plot stage trails it by one cycle to meet the lookup result.
module frame_painter #(
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 240,
    parameter int SPR_W   = 10,
    parameter int SPR_H   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       spr_req,
    input  logic [8:0] spr_x,
    input  logic [8:0] spr_y,
    input  logic [2:0] spr_colour,
    input  logic       spr_erase,
    output logic       spr_ack,
    output logic [8:0] scan_x,
    output logic [8:0] scan_y,
    input  logic [2:0] bg_colour,
    output logic [8:0] vga_x,
    output logic [8:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, FRAME, SPRITE, FLUSH} state_t;

    localparam logic [8:0] FW_LAST = 9'(FRAME_W - 1);
    localparam logic [8:0] FH_LAST = 9'(FRAME_H - 1);
    localparam logic [8:0] SW_LAST = 9'(SPR_W - 1);
    localparam logic [8:0] SH_LAST = 9'(SPR_H - 1);
    localparam logic [9:0] FW_LIM  = 10'(FRAME_W);
    localparam logic [9:0] FH_LIM  = 10'(FRAME_H);

    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic [8:0] cx_q, cx_d, cy_q, cy_d;
    logic [8:0] sx_q, sx_d, sy_q, sy_d;
    logic [2:0] col_q, col_d;
    logic       erase_q, erase_d;

    logic [8:0] vga_x_q, vga_x_d, vga_y_q, vga_y_d;
    logic       plot_q, plot_d;
    logic       use_bg_q, use_bg_d;
    logic [2:0] pcol_q, pcol_d;

    logic [9:0] sum_x, sum_y;
    logic       scan_vld, clip;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        col_d    = col_q;
        erase_d  = erase_q;
        spr_ack  = 1'b0;
        scan_x   = 9'd0;
        scan_y   = 9'd0;
        scan_vld = 1'b0;
        clip     = 1'b0;
        // 10-bit sums so a box hanging past x=511 still reads as off-screen
        sum_x    = {1'b0, sx_q} + {1'b0, cx_q};
        sum_y    = {1'b0, sy_q} + {1'b0, cy_q};

        case (state_q)
            IDLE: begin
                if (start || pend_q) begin
                    state_d = FRAME;
                    pend_d  = 1'b0;
                    cx_d    = 9'd0;
                    cy_d    = 9'd0;
                end else if (spr_req && !reset) begin
                    spr_ack = 1'b1;
                    sx_d    = spr_x;
                    sy_d    = spr_y;
                    col_d   = spr_colour;
                    erase_d = spr_erase;
                    cx_d    = 9'd0;
                    cy_d    = 9'd0;
                    state_d = SPRITE;
                end
            end
            FRAME: begin
                scan_x   = cx_q;
                scan_y   = cy_q;
                scan_vld = 1'b1;
                if (cx_q == FW_LAST) begin
                    cx_d = 9'd0;
                    if (cy_q == FH_LAST) state_d = FLUSH;
                    else                 cy_d = cy_q + 9'd1;
                end else begin
                    cx_d = cx_q + 9'd1;
                end
            end
            SPRITE: begin
                scan_x   = sum_x[8:0];
                scan_y   = sum_y[8:0];
                scan_vld = 1'b1;
                clip     = (sum_x >= FW_LIM) || (sum_y >= FH_LIM);
                if (cx_q == SW_LAST) begin
                    cx_d = 9'd0;
                    if (cy_q == SH_LAST) begin
                        cy_d    = 9'd0;
                        state_d = FLUSH;
                    end else begin
                        cy_d = cy_q + 9'd1;
                    end
                end else begin
                    cx_d = cx_q + 9'd1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start && state_q != IDLE) pend_d = 1'b1;

        // plot stage: colour is picked later, once the lookup has answered
        vga_x_d  = scan_x;
        vga_y_d  = scan_y;
        plot_d   = scan_vld && !clip;
        use_bg_d = (state_q == FRAME) || erase_q;
        pcol_d   = col_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            cx_q     <= 9'd0;
            cy_q     <= 9'd0;
            sx_q     <= 9'd0;
            sy_q     <= 9'd0;
            col_q    <= 3'd0;
            erase_q  <= 1'b0;
            vga_x_q  <= 9'd0;
            vga_y_q  <= 9'd0;
            plot_q   <= 1'b0;
            use_bg_q <= 1'b0;
            pcol_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            col_q    <= col_d;
            erase_q  <= erase_d;
            vga_x_q  <= vga_x_d;
            vga_y_q  <= vga_y_d;
            plot_q   <= plot_d;
            use_bg_q <= use_bg_d;
            pcol_q   <= pcol_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign plot       = plot_q;
    assign vga_colour = use_bg_q ? bg_colour : pcol_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FLUSH);

endmodule

// File: tb/tb_frame_painter.sv
// Bench for frame_painter on an 8x4 frame with 2x2 sprites: job-timeline reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_frame_painter;
    localparam int FW = 8, FH = 4, SW = 2, SH = 2;

    logic       clock = 0, reset = 1, start = 0, spr_req = 0, spr_erase = 0;
    logic [8:0] spr_x = 0, spr_y = 0;
    logic [2:0] spr_colour = 0, bg_colour = 0;
    logic       spr_ack, plot, busy, done;
    logic [8:0] scan_x, scan_y, vga_x, vga_y;
    logic [2:0] vga_colour;

    int checks = 0, errors = 0, cyc = 0;

    frame_painter #(.FRAME_W(FW), .FRAME_H(FH), .SPR_W(SW), .SPR_H(SH)) dut (
        .clock(clock), .reset(reset), .start(start), .spr_req(spr_req),
        .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour), .spr_erase(spr_erase),
        .spr_ack(spr_ack), .scan_x(scan_x), .scan_y(scan_y), .bg_colour(bg_colour),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot),
        .busy(busy), .done(done));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [2:0] lut(input int x, input int y);
        return 3'((x * 5 + y * 3 + 1) & 7);
    endfunction

    // background lookup: one-cycle registered latency
    always @(posedge clock) bg_colour <= lut(int'(scan_x), int'(scan_y));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // reference model: one active job described by grant cycle and pixel count
    bit mvalid = 0, job_act = 0, jframe = 0, jerase = 0, pend = 0;
    int jg = 0, jn = 0, jsx = 0, jsy = 0, jcol = 0;

    typedef struct { int c; int x; int y; int col; } pl_t;
    pl_t plog[$];
    int  done_cnt = 0, last_done = -1, ack_cnt = 0, last_ack = -1;

    function automatic void pix(input int i, output int x, output int y);
        if (jframe) begin x = i % FW;        y = i / FW;        end
        else        begin x = jsx + (i % SW); y = jsy + (i / SW); end
    endfunction

    always @(negedge clock) begin : mon
        int  k, px, py;
        bit  idle, gf, gs, vis;
        pl_t e;
        if (plot === 1'b1) begin
            e.c = cyc; e.x = int'(vga_x); e.y = int'(vga_y); e.col = int'(vga_colour);
            plog.push_back(e);
        end
        if (done === 1'b1) begin done_cnt++; last_done = cyc; end
        if (spr_ack === 1'b1) begin ack_cnt++; last_ack = cyc; end
        if (!mvalid) begin
            if (reset) begin mvalid = 1; job_act = 0; pend = 0; end
        end else begin
            k    = cyc - jg;
            idle = !job_act || k > jn + 1;
            gf   = idle && !reset && (start || pend);
            gs   = idle && !reset && !gf && spr_req;
            chk("spr_ack", spr_ack, gs);
            chk("busy", busy, !idle);
            chk("done", done, !idle && k == jn + 1);
            if (!idle && k <= jn) begin
                pix(k - 1, px, py);
                chk("scan_x", scan_x, px & 511);
                chk("scan_y", scan_y, py & 511);
            end
            if (!idle && k >= 2) begin
                pix(k - 2, px, py);
                vis = px < FW && py < FH;
                chk("plot", plot, vis);
                if (vis) begin
                    chk("vga_x", vga_x, px);
                    chk("vga_y", vga_y, py);
                    chk("vga_colour", vga_colour, (jframe || jerase) ? lut(px, py) : jcol);
                end
            end else begin
                chk("plot", plot, 0);
            end
            if (reset) begin
                job_act = 0; pend = 0;
            end else begin
                if (!idle && start) pend = 1;
                if (gf) begin
                    job_act = 1; jg = cyc; jframe = 1; jn = FW * FH; pend = 0;
                end else if (gs) begin
                    job_act = 1; jg = cyc; jframe = 0; jn = SW * SH;
                    jsx = int'(spr_x); jsy = int'(spr_y); jcol = int'(spr_colour); jerase = spr_erase;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic clear_log();
        plog.delete(); done_cnt = 0; ack_cnt = 0; last_done = -1; last_ack = -1;
    endtask

    task automatic wait_done(input int n, input int limit);
        int i = 0;
        while (done_cnt < n && i < limit) begin tick(); i++; end
        if (done_cnt < n) chk("done_timeout", done_cnt, n);
    endtask

    // spr_req and fields already driven; hold until acknowledged
    task automatic hold_req(output int g, input int limit);
        g = -1;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (spr_ack === 1'b1) begin g = cyc; tick(); spr_req = 0; return; end
            tick();
        end
        spr_req = 0;
        chk("ack_timeout", 0, 1);
    endtask

    task automatic do_sprite(input int x, input int y, input int col, input bit er, output int g);
        spr_x = 9'(x); spr_y = 9'(y); spr_colour = 3'(col); spr_erase = er; spr_req = 1;
        hold_req(g, 50);
    endtask

    initial begin
        int t, g;
        bit got;
        reset = 1;
        repeat (3) tick();
        reset = 0;
        chk("rst_plot", plot, 0);   chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_vga_x", vga_x, 0); chk("rst_vga_y", vga_y, 0); chk("rst_colour", vga_colour, 0);
        chk("rst_ack", spr_ack, 0); chk("rst_scan_x", scan_x, 0);
        tick();

        // full repaint
        clear_log(); t = cyc; start = 1; tick(); start = 0;
        wait_done(1, 200);
        while (cyc < t + 34) tick();
        chk("frame_busy_low", busy, 0);
        chk("frame_plots", plog.size(), 32);
        chk("frame_done_cyc", last_done, t + 33);
        if (plog.size() == 32) begin
            chk("frame_first_cyc", plog[0].c, t + 2);
            chk("frame_first_x", plog[0].x, 0);
            chk("frame_first_col", plog[0].col, 1);
            chk("frame_last_x", plog[31].x, 7);
            chk("frame_last_y", plog[31].y, 3);
            chk("frame_last_col", plog[31].col, 5);
        end

        // draw sprite at (3,1)
        clear_log(); do_sprite(3, 1, 6, 0, g); wait_done(1, 50);
        chk("draw_acks", ack_cnt, 1);
        chk("draw_plots", plog.size(), 4);
        chk("draw_done_cyc", last_done, g + 5);
        if (plog.size() == 4) begin
            chk("draw_p0", plog[0].x * 16 + plog[0].y, 3 * 16 + 1);
            chk("draw_p1", plog[1].x * 16 + plog[1].y, 4 * 16 + 1);
            chk("draw_p2", plog[2].x * 16 + plog[2].y, 3 * 16 + 2);
            chk("draw_p3", plog[3].x * 16 + plog[3].y, 4 * 16 + 2);
            chk("draw_col", plog[3].col, 6);
            chk("draw_first_cyc", plog[0].c, g + 2);
        end
        tick();

        // erase at the bottom-right corner: three of four pixels clipped
        clear_log(); do_sprite(7, 3, 6, 1, g); wait_done(1, 50);
        chk("erase_plots", plog.size(), 1);
        chk("erase_done_cyc", last_done, g + 5);
        if (plog.size() == 1) begin
            chk("erase_xy", plog[0].x * 16 + plog[0].y, 7 * 16 + 3);
            chk("erase_col", plog[0].col, 5);
        end
        tick();

        // simultaneous start and spr_req: repaint wins
        clear_log(); t = cyc;
        start = 1; spr_x = 0; spr_y = 0; spr_colour = 3'd2; spr_erase = 0; spr_req = 1;
        tick(); start = 0;
        hold_req(g, 100);
        chk("prio_ack_cyc", g, t + 34);
        wait_done(2, 50);
        chk("prio_done_cyc", last_done, t + 39);
        chk("prio_plots", plog.size(), 36);
        if (plog.size() == 36) chk("prio_spr_col", plog[32].col, 2);
        tick();

        // three starts during a repaint merge into one more repaint
        clear_log(); t = cyc; start = 1; tick();
        for (int i = 1; i < 120; i++) begin start = (i % 5 == 0 && i <= 15); tick(); end
        start = 0;
        chk("merge_dones", done_cnt, 2);
        chk("merge_plots", plog.size(), 64);
        chk("merge_last_done", last_done, t + 67);

        // reset mid-repaint
        clear_log(); t = cyc; start = 1; tick(); start = 0;
        while (cyc < t + 10) tick();
        reset = 1; tick(); reset = 0;
        chk("abort_plot", plot, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
        clear_log();
        repeat (40) tick();
        chk("abort_no_resume", plog.size() + done_cnt, 0);
        chk("abort_busy_late", busy, 0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 399) == 0);
            if (!spr_req && $urandom_range(0, 7) == 0) begin
                spr_x = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(505, 511)) : 9'($urandom_range(0, 9));
                spr_y = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(505, 511)) : 9'($urandom_range(0, 5));
                spr_colour = 3'($urandom_range(0, 7));
                spr_erase  = 1'($urandom_range(0, 1));
                spr_req    = 1;
            end
            #1; got = (spr_ack === 1'b1);
            @(posedge clock); #1;
            start = 0; reset = 0;
            if (got) spr_req = 0;
        end
        spr_req = 0; start = 0;
        repeat (150) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
